// File: rtl/axil_ctrl_arbiter.sv
// axil_ctrl_arbiter: round-robin arbiter that runs one AXI4-Lite transaction at a time for two requesters.
module axil_ctrl_arbiter #(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      req0_valid,
    input  logic                      req0_we,
    input  logic [C_ADDR_WIDTH-1:0]   req0_addr,
    input  logic [C_DATA_WIDTH-1:0]   req0_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] req0_wstrb,
    output logic                      req0_done,
    output logic [C_DATA_WIDTH-1:0]   req0_rdata,
    output logic [1:0]                req0_resp,
    input  logic                      req1_valid,
    input  logic                      req1_we,
    input  logic [C_ADDR_WIDTH-1:0]   req1_addr,
    input  logic [C_DATA_WIDTH-1:0]   req1_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] req1_wstrb,
    output logic                      req1_done,
    output logic [C_DATA_WIDTH-1:0]   req1_rdata,
    output logic [1:0]                req1_resp,
    output logic                      busy,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);
    typedef enum logic [2:0] {IDLE, WR, WRESP, RD_A, RD_D, DONE} state_t;
    state_t state;
    logic last_grant, gid, grant, sel_we;
    logic [C_ADDR_WIDTH-1:0] sel_addr;
    logic [C_DATA_WIDTH-1:0] sel_wdata;
    logic [C_DATA_WIDTH/8-1:0] sel_wstrb;
    logic [1:0] done_q;
    logic [1:0][C_DATA_WIDTH-1:0] rdata_q;
    logic [1:0][1:0] resp_q;

    // on a tie the requester that did not win last time is granted
    always_comb begin
        grant = (req0_valid && req1_valid) ? !last_grant : req1_valid;
        sel_we = grant ? req1_we : req0_we;
        sel_addr = (grant ? req1_addr : req0_addr) & ~C_ADDR_WIDTH'(3);
        sel_wdata = grant ? req1_wdata : req0_wdata;
        sel_wstrb = grant ? req1_wstrb : req0_wstrb;
    end

    assign req0_done = done_q[0];
    assign req1_done = done_q[1];
    assign req0_rdata = rdata_q[0];
    assign req1_rdata = rdata_q[1];
    assign req0_resp = resp_q[0];
    assign req1_resp = resp_q[1];
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state <= IDLE;
            last_grant <= 1'b1;
            gid <= 1'b0;
            busy <= 1'b0;
            done_q <= '0;
            rdata_q <= '0;
            resp_q <= '0;
            M_AXI_AWADDR <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA <= '0;
            M_AXI_WSTRB <= '0;
            M_AXI_WVALID <= 1'b0;
            M_AXI_BREADY <= 1'b0;
            M_AXI_ARADDR <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_valid || req1_valid) begin
                    gid <= grant;
                    last_grant <= grant;
                    busy <= 1'b1;
                    if (sel_we) begin
                        M_AXI_AWADDR <= sel_addr;
                        M_AXI_WDATA <= sel_wdata;
                        M_AXI_WSTRB <= sel_wstrb;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID <= 1'b1;
                        state <= WR;
                    end else begin
                        M_AXI_ARADDR <= sel_addr;
                        M_AXI_ARVALID <= 1'b1;
                        state <= RD_A;
                    end
                end
                WR: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
                    // a channel counts as complete if it already dropped or handshakes now
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY))
                        state <= WRESP;
                end
                WRESP: if (M_AXI_BREADY && M_AXI_BVALID) begin
                    M_AXI_BREADY <= 1'b0;
                    done_q[gid] <= 1'b1;
                    rdata_q[gid] <= '0;
                    resp_q[gid] <= M_AXI_BRESP;
                    state <= DONE;
                end else begin
                    M_AXI_BREADY <= 1'b1;
                end
                RD_A: if (M_AXI_ARREADY) begin
                    M_AXI_ARVALID <= 1'b0;
                    state <= RD_D;
                end
                RD_D: if (M_AXI_RREADY && M_AXI_RVALID) begin
                    M_AXI_RREADY <= 1'b0;
                    done_q[gid] <= 1'b1;
                    rdata_q[gid] <= M_AXI_RDATA;
                    resp_q[gid] <= M_AXI_RRESP;
                    state <= DONE;
                end else begin
                    M_AXI_RREADY <= 1'b1;
                end
                DONE: begin
                    done_q <= '0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_ctrl_arbiter.sv
// tb_axil_ctrl_arbiter: random and directed traffic against a transaction-level model and a simple register slave.
module tb_axil_ctrl_arbiter;
    localparam int AW = 4, DW = 32;
    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;

    logic rq_valid [2], rq_we [2], rq_done [2];
    logic [AW-1:0] rq_addr [2];
    logic [DW-1:0] rq_wdata [2], rq_rdata [2];
    logic [3:0] rq_wstrb [2];
    logic [1:0] rq_resp [2];
    logic busy;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;

    axil_ctrl_arbiter #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) dut (
        .ACLK(clk), .ARESETN(rstn),
        .req0_valid(rq_valid[0]), .req0_we(rq_we[0]), .req0_addr(rq_addr[0]), .req0_wdata(rq_wdata[0]),
        .req0_wstrb(rq_wstrb[0]), .req0_done(rq_done[0]), .req0_rdata(rq_rdata[0]), .req0_resp(rq_resp[0]),
        .req1_valid(rq_valid[1]), .req1_we(rq_we[1]), .req1_addr(rq_addr[1]), .req1_wdata(rq_wdata[1]),
        .req1_wstrb(rq_wstrb[1]), .req1_done(rq_done[1]), .req1_rdata(rq_rdata[1]), .req1_resp(rq_resp[1]),
        .busy(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [3:0] wstrb;} cmd_t;
    typedef struct packed {logic port; logic [DW-1:0] rdata; logic [1:0] resp; int age; int cyc;} ev_t;

    int n_cmp = 0, n_err = 0, cyc = 0, start_pct = 100;
    cmd_t q0[$], q1[$], cur [2];
    logic act [2];
    ev_t ev_q[$];
    // slave knobs and state
    int aw_dly, w_dly, ar_dly, b_dly, r_dly, aw_age, w_age, ar_age, b_age, r_age;
    logic [1:0] bresp_cfg, rresp_cfg;
    logic aw_got, w_got, b_pend, ar_got, hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [DW-1:0] s_wdata, smem [4];
    logic [3:0] s_wstrb;
    // reference model
    logic m_busy, m_last, m_g, m_skip, m_zw;
    int m_age;
    cmd_t m_cmd;
    logic [DW-1:0] m_rdata, mmem [4];
    logic [1:0] m_resp;
    logic p_aw, p_w, p_ar;
    int cnt_aw, cnt_w, cnt_rr;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = d[8*i +: 8];
        return o;
    endfunction

    task automatic set_slave(input int a, input int w, input int ar, input int b, input int r,
                             input logic [1:0] br, input logic [1:0] rr);
        aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r; bresp_cfg = br; rresp_cfg = rr;
    endtask

    task automatic check();
        if (p_aw && !hs_aw) chk("awvalid_hold", awvalid, 1);
        if (p_w && !hs_w) chk("wvalid_hold", wvalid, 1);
        if (p_ar && !hs_ar) chk("arvalid_hold", arvalid, 1);
        if (bready) chk("bready_before_aw_w", awvalid | wvalid, 0);
        if (rready) chk("rready_before_ar", arvalid, 0);
        if (awvalid) chk("awaddr", awaddr, {m_cmd.addr[AW-1:2], 2'b00});
        if (wvalid) chk("wdata_wstrb", {wstrb, wdata}, {m_cmd.wstrb, m_cmd.wdata});
        if (arvalid) chk("araddr", araddr, {m_cmd.addr[AW-1:2], 2'b00});
        if (awvalid | arvalid) chk("prot", {awprot, arprot}, 0);
        p_aw = awvalid; p_w = wvalid; p_ar = arvalid;
        cnt_aw += int'(awvalid); cnt_w += int'(wvalid); cnt_rr += int'(rready);
        if (m_busy) begin
            m_age++;
            chk("busy", busy, 1);
            if (rq_done[0] || rq_done[1]) begin
                chk("done_port", {rq_done[1], rq_done[0]}, m_g ? 2'b10 : 2'b01);
                chk("rdata", rq_rdata[m_g], m_rdata);
                chk("resp", rq_resp[m_g], m_resp);
                if (m_zw) chk("latency", m_age, 4);
                ev_q.push_back('{port: m_g, rdata: rq_rdata[m_g], resp: rq_resp[m_g], age: m_age, cyc: cyc});
                m_busy = 0; m_skip = 1;
            end else if (m_age > 300) begin
                n_cmp++; n_err++;
                $display("FAIL done_timeout: no done after %0d cycles for req%0d", m_age, m_g);
                m_busy = 0;
            end
        end else begin
            chk("idle_busy", busy, 0);
            chk("idle_done", {rq_done[1], rq_done[0]}, 0);
        end
    endtask

    task automatic slave();
        if (hs_aw) begin aw_got = 1; s_awaddr = awaddr; end
        if (hs_w) begin w_got = 1; s_wdata = wdata; s_wstrb = wstrb; end
        if (hs_b) begin aw_got = 0; w_got = 0; b_pend = 0; end
        if (hs_ar) begin ar_got = 1; s_araddr = araddr; end
        if (hs_r) ar_got = 0;
        awready = awvalid && !aw_got && aw_age >= aw_dly;
        aw_age = (awvalid && !aw_got) ? aw_age + 1 : 0;
        wready = wvalid && !w_got && w_age >= w_dly;
        w_age = (wvalid && !w_got) ? w_age + 1 : 0;
        if (aw_got && w_got && !b_pend) begin
            smem[s_awaddr[AW-1:2]] = merge(smem[s_awaddr[AW-1:2]], s_wdata, s_wstrb);
            b_pend = 1; b_age = 0;
        end
        bvalid = b_pend && b_age >= b_dly;
        bresp = bvalid ? bresp_cfg : 2'b00;
        if (b_pend) b_age++;
        arready = arvalid && !ar_got && ar_age >= ar_dly;
        ar_age = (arvalid && !ar_got) ? ar_age + 1 : 0;
        rvalid = ar_got && r_age >= r_dly;
        rdata = rvalid ? smem[s_araddr[AW-1:2]] : '0;
        rresp = rvalid ? rresp_cfg : 2'b00;
        r_age = ar_got ? r_age + 1 : 0;
        hs_aw = awvalid && awready; hs_w = wvalid && wready; hs_b = bvalid && bready;
        hs_ar = arvalid && arready; hs_r = rvalid && rready;
    endtask

    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            if (act[p] && rq_done[p]) act[p] = 0;
            if (!act[p] && (p == 0 ? q0.size() : q1.size()) != 0 && $urandom_range(99) < start_pct) begin
                if (p == 0) cur[p] = q0.pop_front(); else cur[p] = q1.pop_front();
                act[p] = 1;
            end
            rq_valid[p] = act[p];
            rq_we[p] = act[p] ? cur[p].we : 1'($urandom);
            rq_addr[p] = act[p] ? cur[p].addr : AW'($urandom);
            rq_wdata[p] = act[p] ? cur[p].wdata : $urandom;
            rq_wstrb[p] = act[p] ? cur[p].wstrb : 4'($urandom);
        end
    endtask

    task automatic model_grant();
        logic [1:0] idx;
        if (m_skip) m_skip = 0;
        else if (!m_busy && (rq_valid[0] || rq_valid[1])) begin
            m_g = (rq_valid[0] && rq_valid[1]) ? !m_last : rq_valid[1];
            m_last = m_g; m_cmd = cur[m_g]; m_busy = 1; m_age = 0;
            m_zw = (aw_dly + w_dly + ar_dly + b_dly + r_dly) == 0;
            idx = m_cmd.addr[AW-1:2];
            if (m_cmd.we) begin
                mmem[idx] = merge(mmem[idx], m_cmd.wdata, m_cmd.wstrb);
                m_rdata = '0; m_resp = bresp_cfg;
            end else begin
                m_rdata = mmem[idx]; m_resp = rresp_cfg;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check();
        slave();
        drive();
        model_grant();
    endtask

    task automatic do_reset(input int n);
        rstn = 0;
        q0.delete(); q1.delete();
        for (int p = 0; p < 2; p++) begin act[p] = 0; rq_valid[p] = 0; end
        repeat (n) begin
            @(negedge clk);
            cyc++;
            chk("rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, busy, rq_done[0], rq_done[1]}, 0);
            chk("rst_addr", {awaddr, araddr, wstrb, awprot, arprot}, 0);
            chk("rst_wdata", wdata, 0);
            chk("rst_rdata", {rq_rdata[0], rq_rdata[1]}, 0);
            chk("rst_resp", {rq_resp[0], rq_resp[1]}, 0);
        end
        {aw_got, w_got, b_pend, ar_got, hs_aw, hs_w, hs_b, hs_ar, hs_r} = '0;
        {awready, wready, bvalid, arready, rvalid} = '0;
        bresp = 0; rresp = 0; rdata = 0;
        aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
        for (int i = 0; i < 4; i++) begin smem[i] = 0; mmem[i] = 0; end
        m_busy = 0; m_last = 1; m_skip = 0; m_cmd = '0; p_aw = 0; p_w = 0; p_ar = 0;
        rstn = 1;
    endtask

    task automatic run(input int maxc);
        int c = 0;
        do begin step(); c++; end
        while ((q0.size() != 0 || q1.size() != 0 || act[0] || act[1] || m_busy || m_skip) && c < maxc);
        n_cmp++;
        if (c >= maxc) begin n_err++; $display("FAIL drain: traffic still pending after %0d cycles", c); end
        step(); step();
    endtask

    function automatic cmd_t mk(input logic we, input int a, input logic [31:0] d, input logic [3:0] s);
        return '{we: we, addr: AW'(a), wdata: d, wstrb: s};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int p = 0; p < 2; p++) begin
            rq_valid[p] = 0; rq_we[p] = 0; rq_addr[p] = 0; rq_wdata[p] = 0; rq_wstrb[p] = 0;
        end
        {awready, wready, bvalid, arready, rvalid} = '0;
        bresp = 0; rresp = 0; rdata = 0;
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
        do_reset(3);

        // write then read back four registers, zero-wait slave
        for (int i = 0; i < 4; i++) q0.push_back(mk(1, 4 * i, 32'(i + 1), 4'hF));
        run(200);
        for (int i = 0; i < 4; i++) q1.push_back(mk(0, 4 * i, 0, 0));
        run(200);
        chk("t1_count", ev_q.size(), 8);
        chk("t1_b2b", ev_q[1].cyc - ev_q[0].cyc, 5);
        for (int i = 0; i < 4; i++) begin
            chk("t1_rd_port", ev_q[4 + i].port, 1);
            chk("t1_rd_data", ev_q[4 + i].rdata, i + 1);
            chk("t1_rd_resp", ev_q[4 + i].resp, 0);
        end

        // tie from reset: req0 first, then alternating
        ev_q.delete();
        do_reset(2);
        q0.push_back(mk(1, 0, 32'hA5A5A5A5, 4'hF)); q0.push_back(mk(1, 4, 32'h11, 4'hF));
        q1.push_back(mk(0, 0, 0, 0)); q1.push_back(mk(0, 4, 0, 0));
        run(200);
        chk("t2_order", {ev_q[0].port, ev_q[1].port, ev_q[2].port, ev_q[3].port}, 4'b0101);
        chk("t2_rd0", ev_q[1].rdata, 32'hA5A5A5A5);
        chk("t2_rd1", ev_q[3].rdata, 32'h11);

        // AW held off three cycles while W is accepted at once
        set_slave(3, 0, 0, 0, 0, 2'b00, 2'b00);
        cnt_aw = 0; cnt_w = 0;
        q0.push_back(mk(1, 8, 32'hDEADBEEF, 4'h5));
        run(200);
        chk("t3_aw_cycles", cnt_aw, 4);
        chk("t3_w_cycles", cnt_w, 1);

        // error responses pass through
        ev_q.delete();
        set_slave(0, 0, 0, 0, 0, 2'b10, 2'b11);
        q1.push_back(mk(1, 12, 32'hCAFE0001, 4'hF)); q1.push_back(mk(0, 13, 0, 0));
        run(200);
        chk("t4_wr_resp", ev_q[0].resp, 2'b10);
        chk("t4_rd_resp", ev_q[1].resp, 2'b11);
        chk("t4_rd_data", ev_q[1].rdata, 32'hCAFE0001);

        // reset while waiting for the write response
        set_slave(0, 0, 0, 6, 0, 2'b00, 2'b00);
        q0.push_back(mk(1, 4, 32'h55, 4'hF));
        for (int k = 0; k < 50 && !(m_busy && m_age >= 3); k++) step();
        chk("t5_in_wresp", bready, 1);
        do_reset(1);
        ev_q.delete();
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
        q1.push_back(mk(0, 4, 0, 0));
        run(200);
        chk("t5_count", ev_q.size(), 1);
        chk("t5_port_data", {ev_q[0].port, ev_q[0].rdata}, {1'b1, 32'h0});

        // slow read data; req1 arrives meanwhile and waits
        ev_q.delete();
        set_slave(0, 0, 0, 0, 10, 2'b00, 2'b00);
        cnt_rr = 0;
        q0.push_back(mk(0, 0, 0, 0));
        repeat (3) step();
        q1.push_back(mk(1, 0, 32'h77, 4'h3));
        run(300);
        chk("t6_rready_cycles", cnt_rr, 10);
        chk("t6_order", {ev_q[0].port, ev_q[1].port}, 2'b01);

        // random traffic with random slave timing and responses
        start_pct = 60;
        for (int r = 0; r < 6; r++) begin
            set_slave($urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3),
                      $urandom_range(3), 2'($urandom), 2'($urandom));
            for (int i = 0; i < 12; i++) begin
                cmd_t c = mk(1'($urandom), $urandom_range(15), $urandom, 4'($urandom));
                if ($urandom_range(1) == 0) q0.push_back(c); else q1.push_back(c);
            end
            run(2000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axil_ctrl_arbiter.md
# axil_ctrl_arbiter

Two-port arbiter and AXI4-Lite master sequencer that shares one AXI4-Lite register slave (4 × 32-bit control registers) between two on-chip requesters, e.g. the vector-processor control unit and a host command path. Each requester issues single-word read or write commands on a simple valid/done port. The block grants them round-robin, runs exactly one AXI4-Lite transaction at a time, and returns read data and response on a one-cycle done pulse.

## Interface
- C_ADDR_WIDTH, 4, byte address width of slave register space
- C_DATA_WIDTH, 32, data width (only 32 supported)
- ACLK  in  1  clock, all logic rising-edge
- ARESETN  in  1  synchronous, active-low reset
- reqN_valid  in  1  (N=0,1) command request; held with stable fields until reqN_done
- reqN_we  in  1  1=write, 0=read
- reqN_addr  in  C_ADDR_WIDTH  byte address; bits [1:0] ignored (forced 0 on bus)
- reqN_wdata  in  C_DATA_WIDTH  write data
- reqN_wstrb  in  C_DATA_WIDTH/8  write strobes
- reqN_done  out  1  one-cycle completion pulse
- reqN_rdata  out  C_DATA_WIDTH  read data, valid with reqN_done (0 for writes)
- reqN_resp  out  2  BRESP/RRESP, valid with reqN_done
- busy  out  1  high in every state except IDLE
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master, widths per parameters; AWPROT=ARPROT=3'b000 constant

## Operation
- FSM states: IDLE, WR (AW/W issue), WRESP, RD_A, RD_D, DONE.
- IDLE: if any reqN_valid, grant. If both are valid, grant the requester not in last_grant. last_grant resets to 1, so req0 wins the first tie. Latch we/addr/wdata/wstrb and the grant id into command registers. Update last_grant. Go to WR (we=1) or RD_A (we=0).
- WR: AWVALID and WVALID assert together on entry. Each drops independently the cycle after its own handshake (VALID&READY). Go to WRESP when both handshakes are complete, including the case where both complete in the same cycle.
- WRESP: BREADY=1. On BVALID, capture BRESP and go to DONE.
- RD_A: ARVALID=1 until ARREADY, then RD_D.
- RD_D: RREADY=1. On RVALID, capture RDATA/RRESP and go to DONE.
- DONE: the granted reqN_done=1 for exactly one cycle, with rdata/resp from registers. The other requester's done stays 0. Return to IDLE next cycle.
- reqN_valid sampled in IDLE after DONE is a new command. The requester must drop valid in the DONE cycle if it has nothing further.
- Requests arriving outside IDLE wait. Command fields are ignored after latch.
- No timeout. A hung slave holds the FSM in its current state.

## Timing
- Reset values: all M_AXI VALID/READY 0; AWADDR/ARADDR/WDATA/WSTRB 0; reqN_done 0; reqN_rdata 0; reqN_resp 0; busy 0; FSM IDLE; last_grant 1.
- All outputs are registered; no combinational path from any input to any output.
- Grant at cycle T (IDLE, valid high) → AWVALID/WVALID or ARVALID high at T+1.
- With zero-wait slave (READY high, B/R returned the cycle after address): write done at T+4, read done at T+4. Issue back-to-back commands every 5 cycles.
- AXI rules: VALID is never dropped before its handshake. ADDR/DATA are stable while VALID. READY is asserted only in WRESP/RD_D.
- ARESETN low at any edge, including mid-transaction: next state is all reset values. The in-flight transaction is abandoned; the slave shares ARESETN. No done pulse for the abandoned command.

## Test plan
- Write/read path: req0 writes 0x00000001..0x00000004 to 0x0,0x4,0x8,0xC (wstrb 0xF). req1 then reads the same four addresses → rdata 1,2,3,4, resp 0, four done pulses on req1 only.
- Tie arbitration: both valid from reset, req0 write 0xA5A5A5A5@0x0, req1 read @0x0 → req0 done first, then req1 done with rdata 0xA5A5A5A5. Both kept valid for 4 commands → grants alternate 0,1,0,1.
- Split AW/W: slave holds AWREADY low 3 cycles with WREADY immediate → WVALID drops after its handshake, AWVALID held 4 cycles. No BREADY before both handshakes.
- Error pass-through: slave returns BRESP=2'b10 on write, RRESP=2'b11 on read → reqN_resp 2'b10 then 2'b11 with matching done.
- Reset mid-op: ARESETN low while in WRESP → next cycle all outputs at reset values. After release, req1 read @0x4 completes normally with no stale done.
- Backpressure hold: RVALID delayed 10 cycles → RREADY held high, busy high throughout. A req1 request arriving meanwhile is granted only after DONE.
